// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline definitions: skid-stage state encoding and default payload width.
package pipe_stage_skid_pkg;

  localparam int DEFAULT_WIDTH = 256;

  // The encoding doubles as the occupancy count presented on the stage output.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline register with registered in_ready, flush and
// a saturating stall counter; one instance per IF/ID, ID/EX, EX/MEM, MEM/WB.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int               WIDTH         = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PAYLOAD = '0,
  parameter int               CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             acc_evt;
  logic             rel_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign in_ready  = in_ready_q;
  assign stall_cnt = stall_q;
  assign acc_evt   = in_valid & in_ready_q;
  assign rel_evt   = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;

    // The stall counter observes the handshake even in a flush cycle.
    if (out_valid && !out_ready) stall_d = sat_inc(stall_q);

    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = RESET_PAYLOAD;
      skid_d  = RESET_PAYLOAD;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (acc_evt) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (acc_evt && !rel_evt) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (!acc_evt && rel_evt) begin
            state_d = ST_EMPTY;
          end else if (acc_evt && rel_evt) begin
            main_d  = in_data;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a release can occur.
          if (rel_evt) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    // Registering the next-state comparison keeps out_ready off the in_ready path.
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      main_q     <= RESET_PAYLOAD;
      skid_q     <= RESET_PAYLOAD;
      in_ready_q <= 1'b1;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      stall_q    <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomised and directed bench for pipe_stage_skid against a FIFO-queue reference model.
module tb_pipe_stage_skid;

  localparam int               W  = 32;
  localparam logic [W-1:0]     RP = 32'hDEAD_BEEF;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;
  logic [15:0]  stall_cnt;

  logic         d2_in_ready, d2_out_valid;
  logic [W-1:0] d2_out_data;
  logic [1:0]   d2_occupancy;
  logic [3:0]   d2_stall_cnt;

  int passed = 0;
  int total  = 0;
  int shown  = 0;

  logic [W-1:0] mq[$];
  int           mstall;
  int           mstall4;

  always #5 clk = ~clk;

  pipe_stage_skid #(.WIDTH(W), .RESET_PAYLOAD(RP), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(.WIDTH(W), .RESET_PAYLOAD(RP), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(d2_in_ready), .in_data(in_data),
    .out_valid(d2_out_valid), .out_ready(out_ready), .out_data(d2_out_data),
    .occupancy(d2_occupancy), .stall_cnt(d2_stall_cnt)
  );

  // One clock: drive inputs, advance the queue model, sample 1 time unit after the edge.
  task automatic cycle(input logic rst, input logic fl, input logic iv,
                       input logic [W-1:0] d, input logic ordy);
    bit acc, rel;
    reset = rst; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    @(posedge clk);
    if (rst) begin
      mq.delete(); mstall = 0; mstall4 = 0;
    end else begin
      if (mq.size() > 0 && !ordy) begin
        if (mstall < 65535) mstall++;
        if (mstall4 < 15) mstall4++;
      end
      if (fl) mq.delete();
      else begin
        acc = iv && (mq.size() < 2);
        rel = (mq.size() > 0) && ordy;
        if (rel) void'(mq.pop_front());
        if (acc) mq.push_back(d);
      end
    end
    #1;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    total++; if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid got=%0b want=0", out_valid); end else passed++;
    total++; if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready got=%0b want=1", in_ready); end else passed++;
    total++; if (occupancy !== 2'd0) begin $display("FAIL reset_occupancy got=%0d want=0", occupancy); end else passed++;
    total++; if (out_data !== RP) begin $display("FAIL reset_out_data got=%h want=%h", out_data, RP); end else passed++;
    total++; if (stall_cnt !== 16'd0) begin $display("FAIL reset_stall_cnt got=%0d want=0", stall_cnt); end else passed++;
    total++; if ({d2_out_valid, d2_in_ready, d2_occupancy, d2_stall_cnt} !== {1'b0, 1'b1, 2'd0, 4'd0} || d2_out_data !== RP)
      begin $display("FAIL reset_dut4 got=%b/%b/%0d/%0d/%h", d2_out_valid, d2_in_ready, d2_occupancy, d2_stall_cnt, d2_out_data); end
    else passed++;
  endtask

  task automatic test_stream();
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 32'hA, 1'b1);
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'hA || occupancy !== 2'd1 || in_ready !== 1'b1) begin
        $display("FAIL stream_cyc%0d got v=%0b d=%h occ=%0d rdy=%0b want v=1 d=a occ=1 rdy=1",
                 i, out_valid, out_data, occupancy, in_ready);
      end else passed++;
    end
  endtask

  task automatic test_fill_drain();
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h2, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h3, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h4, 1'b0);
    total++; if (occupancy !== 2'd2) begin $display("FAIL fill_occupancy got=%0d want=2", occupancy); end else passed++;
    total++; if (in_ready !== 1'b0) begin $display("FAIL fill_in_ready got=%0b want=0", in_ready); end else passed++;
    total++; if (out_data !== 32'h1) begin $display("FAIL fill_out_data got=%h want=1", out_data); end else passed++;
    total++; if (stall_cnt !== 16'd3 || int'(stall_cnt) !== mstall)
      begin $display("FAIL fill_stall_cnt got=%0d want=3", stall_cnt); end else passed++;
    total++; if (out_valid !== 1'b1 || out_data !== 32'h1) begin $display("FAIL drain_first got=%0b/%h want=1/1", out_valid, out_data); end else passed++;
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
    total++; if (out_valid !== 1'b1 || out_data !== 32'h2 || occupancy !== 2'd1)
      begin $display("FAIL drain_second got=%0b/%h/%0d want=1/2/1", out_valid, out_data, occupancy); end else passed++;
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
    total++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1)
      begin $display("FAIL drain_empty got=%0b/%0d/%0b want=0/0/1", out_valid, occupancy, in_ready); end else passed++;
  endtask

  task automatic test_flush();
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h2, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'h5, 1'b1);
    total++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      begin $display("FAIL flush_state got=%0d/%0b/%0b want=0/0/1", occupancy, out_valid, in_ready); end else passed++;
    total++; if (out_data !== RP) begin $display("FAIL flush_out_data got=%h want=%h", out_data, RP); end else passed++;
    total++; if (int'(stall_cnt) !== mstall || stall_cnt === 16'd0)
      begin $display("FAIL flush_keeps_stall got=%0d want=%0d", stall_cnt, mstall); end else passed++;
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
    total++; if (out_valid !== 1'b0) begin $display("FAIL flush_no_emit got=%0b want=0", out_valid); end else passed++;
  endtask

  task automatic test_accept_release();
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h11, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h22, 1'b1);
    total++; if (occupancy !== 2'd1 || out_data !== 32'h22 || out_valid !== 1'b1)
      begin $display("FAIL accept_release got=%0d/%h want=1/22", occupancy, out_data); end else passed++;
  endtask

  task automatic test_stall_sat();
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h7, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
    total++; if (d2_stall_cnt !== 4'd15 || mstall4 !== 15)
      begin $display("FAIL stall_sat4 got=%0d want=15", d2_stall_cnt); end else passed++;
    total++; if (stall_cnt !== 16'd20) begin $display("FAIL stall_cnt16 got=%0d want=20", stall_cnt); end else passed++;
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 1'b0, 1'b1, 32'h8, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'h9, 1'b1);
    total++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== RP || stall_cnt !== 16'd0)
      begin $display("FAIL reset_mid got=%0d/%0b/%0b/%h/%0d want=0/0/1/%h/0", occupancy, out_valid, in_ready, out_data, stall_cnt, RP); end
    else passed++;
  endtask

  task automatic test_random();
    logic         iv, ordy, fl, pv;
    logic [W-1:0] d, pd;
    int           bad;
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 63) == 0);
      d    = $urandom();
      pv   = out_valid;
      pd   = out_data;
      cycle(1'b0, fl, iv, d, ordy);
      total++;
      if (out_valid !== (mq.size() > 0) || int'(occupancy) !== mq.size() ||
          in_ready !== (mq.size() < 2) || int'(stall_cnt) !== mstall ||
          (mq.size() > 0 && out_data !== mq[0])) begin
        if (bad < 20) $display("FAIL random_cyc%0d got v=%0b occ=%0d rdy=%0b st=%0d d=%h want occ=%0d st=%0d d=%h",
                               i, out_valid, occupancy, in_ready, stall_cnt, out_data, mq.size(), mstall,
                               (mq.size() > 0) ? mq[0] : RP);
        bad++;
      end else passed++;
      if (pv && !ordy && !fl) begin
        total++;
        if (out_data !== pd) begin
          if (bad < 20) $display("FAIL random_hold_cyc%0d got=%h want=%h", i, out_data, pd);
          bad++;
        end else passed++;
      end
    end
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    mstall = 0; mstall4 = 0;
    #1;
    test_reset();
    test_stream();
    test_fill_drain();
    test_flush();
    test_accept_release();
    test_stall_sat();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
